result_display_scan: RTL and testbench
======================================

RESULT_DISPLAY_SCAN -- requirements
Module: result_display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, giving the clock cycles per digit scan slot (legal range 2..2^20).
REQ-002 SHALL have parameter BLANK_LZ, default 1, which enables leading-zero blanking of the high digit when set to 1.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port value, input, 8 bits: the result word from the comparison stage; only bits 3:0 are non-zero for max, and only bit 0 for boolean operations.
REQ-006 SHALL have port load, input, 1 bit: a level request; a rising edge captures value.
REQ-007 SHALL have port seg, output, 7 bits: segment drive, active-low, bit order gfedcba.
REQ-008 SHALL have port digit_en, output, 2 bits: digit enables, active-low; bit 0 is the low digit and bit 1 is the high digit.
REQ-009 SHALL have port valid, output, 1 bit: high once at least one value has been captured since reset.

Function
REQ-010 SHALL register load into load_q every cycle; a capture edge SHALL be defined as load=1 with load_q=0.
REQ-011 On a capture edge, held[7:0] SHALL take the value sampled in that same cycle; no other cycle SHALL modify held.
REQ-012 valid SHALL set on the first capture edge and SHALL stay high until reset.
REQ-013 The prescaler SHALL count from 0 to SCAN_DIV-1 and wrap to 0; the wrap cycle SHALL assert an internal tick.
REQ-014 On tick, digit_sel SHALL toggle between 0 (low digit) and 1 (high digit).
REQ-015 seg and digit_en SHALL be registered outputs, updating exactly one cycle after any change of held, valid or digit_sel.
REQ-016 When digit_sel=0, digit_en SHALL be 2'b10 and seg SHALL be hex_decode(held[3:0]).
REQ-017 When digit_sel=1, digit_en SHALL be 2'b01 and seg SHALL be hex_decode(held[7:4]).
REQ-018 When digit_sel=1, BLANK_LZ=1 and held[7:4]=0, seg SHALL instead be 7'b1111111 (blank), with digit_en still 2'b01.
REQ-019 When valid=0, seg SHALL be 7'b0111111 (dash, segment g only) for both digits, overriding REQ-016 to REQ-018.
REQ-020 hex_decode SHALL cover all 16 codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 When a capture edge and a tick occur in the same cycle, both SHALL take effect, and the newly selected digit SHALL show the new held value one cycle later.
REQ-022 When load stays high, only one capture SHALL occur, and a new capture SHALL require load to return low for at least one cycle.
REQ-023 digit_en SHALL never have both bits low (0) in any cycle.

Reset
REQ-024 While reset=1 at a rising edge, the block SHALL set held=0, valid=0, prescaler=0, digit_sel=0, seg=7'b1111111, digit_en=2'b11 and load_q=1.
REQ-025 Because load_q resets to 1, a load held high through reset SHALL NOT cause a capture until it falls and rises again.
REQ-026 Reset asserted mid-scan or mid-capture SHALL take priority over all other events in that cycle.
REQ-027 After reset is released, normal output SHALL appear one cycle later: dashes with digit_en=2'b10.

Verification (SCAN_DIV=4, BLANK_LZ=1 unless stated)
REQ-028 Release reset with load=0 -> valid=0; seg=0111111; digit_en alternates 10 and 01 every 4 cycles.
REQ-029 Pulse load with value=8'h07 -> valid=1 next cycle; low slot seg=1111000; high slot seg=1111111 (blanked).
REQ-030 Pulse load with value=8'h3A and BLANK_LZ=0 -> low slot seg=0001000; high slot seg=0110000.
REQ-031 Hold load=1 for 20 cycles while value changes from 8'h01 to 8'h05 -> held stays 8'h01; after load falls and rises again, held=8'h05.
REQ-032 Assert reset with load=1 and then release it -> no capture and valid=0; a load fall then rise with value=8'h00 -> low seg=1000000 and high blank.
REQ-033 Sweep value over 8'h00..8'h0F, one capture per slot -> each low-digit seg matches the REQ-020 table, and digit_en is never 2'b00.

Source files
------------

// File: rtl/result_display_scan.sv
// result_display_scan: two-digit multiplexed seven-segment display of a captured result byte
//   clk      - system clock, all state changes on its rising edge
//   reset    - synchronous active-high reset
//   value    - result word, captured on a rising edge of load
//   load     - level request; its rising edge captures value
//   seg      - segment drive, active-low, bit order gfedcba
//   digit_en - digit enables, active-low; bit 0 low digit, bit 1 high digit
//   valid    - high once a value has been captured since reset
module result_display_scan #(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value,
    input  logic       load,
    output logic [6:0] seg,
    output logic [1:0] digit_en,
    output logic       valid
);
    localparam int W = $clog2(SCAN_DIV);
    logic [W-1:0] prescaler;
    logic [7:0] held;
    logic loadQ, digitSel, capture, tick;
    logic [3:0] nibble;
    logic [6:0] hexSeg, nextSeg;
    // loadQ resets high so a load held through reset must fall before it can capture
    assign capture = load & ~loadQ;
    assign tick = prescaler == W'(SCAN_DIV - 1);
    assign nibble = digitSel ? held[7:4] : held[3:0];
    always_comb begin
        case (nibble)
            4'h0: hexSeg = 7'b1000000;
            4'h1: hexSeg = 7'b1111001;
            4'h2: hexSeg = 7'b0100100;
            4'h3: hexSeg = 7'b0110000;
            4'h4: hexSeg = 7'b0011001;
            4'h5: hexSeg = 7'b0010010;
            4'h6: hexSeg = 7'b0000010;
            4'h7: hexSeg = 7'b1111000;
            4'h8: hexSeg = 7'b0000000;
            4'h9: hexSeg = 7'b0010000;
            4'hA: hexSeg = 7'b0001000;
            4'hB: hexSeg = 7'b0000011;
            4'hC: hexSeg = 7'b1000110;
            4'hD: hexSeg = 7'b0100001;
            4'hE: hexSeg = 7'b0000110;
            default: hexSeg = 7'b0001110;
        endcase
    end
    // dash before any capture, then blank a zero high digit when enabled
    always_comb nextSeg = !valid ? 7'b0111111
                        : (digitSel && BLANK_LZ && held[7:4] == 4'h0) ? 7'b1111111
                        : hexSeg;
    always_ff @(posedge clk) begin
        if (reset) begin
            loadQ     <= 1'b1;
            held      <= '0;
            valid     <= 1'b0;
            prescaler <= '0;
            digitSel  <= 1'b0;
            seg       <= 7'b1111111;
            digit_en  <= 2'b11;
        end else begin
            loadQ     <= load;
            if (capture) begin
                held  <= value;
                valid <= 1'b1;
            end
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) digitSel <= ~digitSel;
            seg       <= nextSeg;
            digit_en  <= digitSel ? 2'b01 : 2'b10;
        end
    end
endmodule

// File: tb/tb_result_display_scan.sv
// tb_result_display_scan: randomized and directed checks of result_display_scan against a reference model
module tb_result_display_scan;
    localparam int DIV = 4;
    logic clk = 0, reset = 1, load = 0;
    logic [7:0] value = 0;
    logic [6:0] seg, segNb;
    logic [1:0] digit_en, enNb;
    logic valid, validNb;
    int nCmp = 0, nBad = 0;
    logic [6:0] hexTab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    result_display_scan #(.SCAN_DIV(DIV), .BLANK_LZ(1)) dut (
        .clk(clk), .reset(reset), .value(value), .load(load),
        .seg(seg), .digit_en(digit_en), .valid(valid));
    result_display_scan #(.SCAN_DIV(DIV), .BLANK_LZ(0)) dutNb (
        .clk(clk), .reset(reset), .value(value), .load(load),
        .seg(segNb), .digit_en(enNb), .valid(validNb));

    always #5 clk = ~clk;

    // reference model: state after each edge, outputs derived from state before the edge
    logic [7:0] mHeld;
    logic mValid, mSel, mLoadPrev;
    int mCount;
    logic [6:0] expSeg, expSegNb;
    logic [1:0] expEn;
    always @(posedge clk) begin
        if (reset) begin
            mHeld = 0; mValid = 0; mSel = 0; mLoadPrev = 1; mCount = 0;
            expSeg = 7'h7F; expSegNb = 7'h7F; expEn = 2'b11;
        end else begin
            expEn = mSel ? 2'b01 : 2'b10;
            expSegNb = !mValid ? 7'b0111111 : hexTab[mSel ? mHeld[7:4] : mHeld[3:0]];
            expSeg = (mValid && mSel && mHeld[7:4] == 0) ? 7'h7F : expSegNb;
            if (load && !mLoadPrev) begin mHeld = value; mValid = 1; end
            mLoadPrev = load;
            mCount = (mCount + 1) % DIV;
            if (mCount == 0) mSel = !mSel;
        end
    end

    task automatic test_reset;
        reset = 1; load = 0;
        repeat (2) @(negedge clk);
        nCmp++;
        if ({seg, digit_en, valid} !== {7'h7F, 2'b11, 1'b0}) begin
            nBad++; $display("FAIL reset_state: seg=%b en=%b valid=%b want 1111111 11 0", seg, digit_en, valid);
        end
        reset = 0;
        @(negedge clk);
        nCmp++;
        if ({seg, digit_en, valid} !== {7'b0111111, 2'b10, 1'b0}) begin
            nBad++; $display("FAIL reset_release: seg=%b en=%b valid=%b want 0111111 10 0", seg, digit_en, valid);
        end
    endtask

    task automatic test_idle_scan;
        logic [1:0] prevEn = digit_en;
        int runLen = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            nCmp++;
            if ({seg, segNb, digit_en, valid} !== {expSeg, expSegNb, expEn, mValid}) begin
                nBad++; $display("FAIL idle_scan: seg=%b en=%b valid=%b want %b %b %b", seg, digit_en, valid, expSeg, expEn, mValid);
            end
            runLen = (digit_en == prevEn) ? runLen + 1 : 1;
            prevEn = digit_en;
            nCmp++;
            if (seg !== 7'b0111111 || runLen > DIV || digit_en == 2'b00 || digit_en == 2'b11) begin
                nBad++; $display("FAIL idle_dash: seg=%b en=%b run=%0d want 0111111, run<=%0d", seg, digit_en, runLen, DIV);
            end
        end
    endtask

    task automatic test_capture_07;
        value = 8'h07; load = 1;
        @(negedge clk); load = 0;
        @(negedge clk);
        nCmp++;
        if (valid !== 1'b1) begin nBad++; $display("FAIL capture_valid: valid=%b want 1", valid); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            nCmp++;
            if ({seg, segNb, digit_en, valid} !== {expSeg, expSegNb, expEn, mValid}) begin
                nBad++; $display("FAIL capture_07: seg=%b en=%b want %b %b", seg, digit_en, expSeg, expEn);
            end
            nCmp++;
            if (seg !== (digit_en == 2'b10 ? 7'b1111000 : 7'b1111111)) begin
                nBad++; $display("FAIL capture_07_const: seg=%b en=%b", seg, digit_en);
            end
        end
    endtask

    task automatic test_noblank_3a;
        value = 8'h3A; load = 1;
        @(negedge clk); load = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            nCmp++;
            if ({segNb, enNb} !== {expSegNb, expEn}) begin
                nBad++; $display("FAIL noblank_3a: seg=%b en=%b want %b %b", segNb, enNb, expSegNb, expEn);
            end
            nCmp++;
            if (segNb !== (enNb == 2'b10 ? 7'b0001000 : 7'b0110000) || seg !== segNb) begin
                nBad++; $display("FAIL noblank_3a_const: segNb=%b seg=%b en=%b", segNb, seg, enNb);
            end
        end
    endtask

    task automatic test_hold_load;
        value = 8'h01; load = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 2) value = 8'h05;
            nCmp++;
            if ({seg, digit_en} !== {expSeg, expEn}) begin
                nBad++; $display("FAIL hold_load: seg=%b en=%b want %b %b", seg, digit_en, expSeg, expEn);
            end
            if (i > 2 && digit_en == 2'b10) begin
                nCmp++;
                if (seg !== hexTab[1]) begin nBad++; $display("FAIL hold_load_held: seg=%b want %b", seg, hexTab[1]); end
            end
        end
        load = 0;
        @(negedge clk); load = 1;
        @(negedge clk); load = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0 && digit_en == 2'b10) begin
                nCmp++;
                if (seg !== hexTab[5]) begin nBad++; $display("FAIL hold_load_recap: seg=%b want %b", seg, hexTab[5]); end
            end
        end
    endtask

    task automatic test_reset_load_high;
        load = 1; value = 8'h99; reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            nCmp++;
            if (valid !== 1'b0 || seg !== 7'b0111111) begin
                nBad++; $display("FAIL reset_load_high: valid=%b seg=%b want 0 0111111", valid, seg);
            end
        end
        load = 0; value = 8'h00;
        @(negedge clk); load = 1;
        @(negedge clk); load = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0) begin
                nCmp++;
                if (seg !== (digit_en == 2'b10 ? 7'b1000000 : 7'b1111111) || valid !== 1'b1) begin
                    nBad++; $display("FAIL reset_load_zero: seg=%b en=%b valid=%b", seg, digit_en, valid);
                end
            end
        end
    endtask

    task automatic test_sweep;
        for (int v = 0; v < 16; v++) begin
            logic [6:0] lowSeg = 7'hXX;
            value = 8'(v); load = 1;
            @(negedge clk); load = 0;
            for (int i = 0; i < 2 * DIV + 1; i++) begin
                @(negedge clk);
                if (i > 0 && digit_en == 2'b10) lowSeg = seg;
                nCmp++;
                if (digit_en == 2'b00 || {seg, digit_en} !== {expSeg, expEn}) begin
                    nBad++; $display("FAIL sweep_cycle: v=%0d seg=%b en=%b want %b %b", v, seg, digit_en, expSeg, expEn);
                end
            end
            nCmp++;
            if (lowSeg !== hexTab[v]) begin nBad++; $display("FAIL sweep_low: v=%0d seg=%b want %b", v, lowSeg, hexTab[v]); end
        end
    endtask

    task automatic test_capture_on_tick;
        int guard = 0;
        while (mCount != DIV - 1 && guard < 2 * DIV) begin @(negedge clk); guard++; end
        nCmp++;
        if (mCount != DIV - 1) begin nBad++; $display("FAIL tick_align: count=%0d want %0d", mCount, DIV - 1); end
        value = 8'hC4; load = 1;
        @(negedge clk); load = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nCmp++;
            if ({seg, segNb, digit_en, valid} !== {expSeg, expSegNb, expEn, mValid}) begin
                nBad++; $display("FAIL capture_on_tick: seg=%b en=%b want %b %b", seg, digit_en, expSeg, expEn);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            nCmp++;
            if ({seg, segNb, digit_en, valid} !== {expSeg, expSegNb, expEn, mValid} || digit_en == 2'b00) begin
                nBad++; $display("FAIL random: i=%0d seg=%b segNb=%b en=%b valid=%b want %b %b %b %b",
                                 i, seg, segNb, digit_en, valid, expSeg, expSegNb, expEn, mValid);
            end
            reset = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 3) == 0) load = ~load;
            value = 8'($urandom);
        end
        reset = 0;
    endtask

    initial begin
        test_reset;
        test_idle_scan;
        test_capture_07;
        test_noblank_3a;
        test_hold_load;
        test_reset_load_high;
        test_sweep;
        test_capture_on_tick;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
